// File: rtl/alu_srcb_stage_if.sv
// Operand-B stage bundle interface: upstream valid/ready operand bundle,
// optional write-back bypass inputs, and the downstream valid/ready result.
// master = the side driving operands and consuming alu_b; slave = the stage.
interface alu_srcb_stage_if #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     register_b;
    logic [IMM_WIDTH-1:0] immediate;
    logic [5:0]           opcode;
    logic [1:0]           alu_src_b;
    logic [4:0]           rt_index;
    logic                 wb_valid;
    logic [4:0]           wb_index;
    logic [WIDTH-1:0]     wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     alu_b;

    modport master (
        output in_valid, register_b, immediate, opcode, alu_src_b,
               rt_index, wb_valid, wb_index, wb_data, out_ready,
        input  in_ready, out_valid, alu_b
    );

    modport slave (
        input  in_valid, register_b, immediate, opcode, alu_src_b,
               rt_index, wb_valid, wb_index, wb_data, out_ready,
        output in_ready, out_valid, alu_b
    );
endinterface

// File: rtl/alu_srcb_stage.sv
// alu_srcb_stage: immediate extension and ALU operand-B selection, registered
// behind a two-entry skid buffer (output register + skid register).
// Optional feature macro: ALU_SRCB_FWD_EN compiles in the write-back bypass
// for source 0 (register operand). Without it rt_index/wb_* are ignored.
module alu_srcb_stage #(
    parameter int          WIDTH     = 32,
    parameter int          IMM_WIDTH = 16,
    parameter int          SHIFT     = 2,
    parameter int unsigned CONST_B   = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_srcb_stage_if.slave   bus_if
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] reg_val;
    logic [WIDTH-1:0] operand;

    // Extend the instruction immediate according to the opcode class.
    // LUI places the immediate in the upper half of a 32-bit word and then
    // sign-extends that word, so on a 64-bit datapath bit 31 fills the top.
    function automatic logic [WIDTH-1:0] extend_imm(
        input logic [5:0]           op,
        input logic [IMM_WIDTH-1:0] imm
    );
        logic signed [IMM_WIDTH-1:0] imm_s;
        logic signed [31:0]          lui_s;
        imm_s = $signed(imm);
        lui_s = $signed(32'(imm) << 16);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
            return WIDTH'(imm);
        end else if (op == 6'h0F) begin
            return WIDTH'(lui_s);
        end else begin
            return WIDTH'(imm_s);
        end
    endfunction

    // Register-source value, optionally bypassed from write-back. The value
    // is captured at accept time, so later write-backs never touch held data.
`ifdef ALU_SRCB_FWD_EN
    always_comb begin
        reg_val = bus_if.register_b;
        if (bus_if.wb_valid && (bus_if.wb_index == bus_if.rt_index) &&
            (bus_if.rt_index != 5'd0)) begin
            reg_val = bus_if.wb_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus_if.rt_index, bus_if.wb_valid,
                          bus_if.wb_index, bus_if.wb_data};
    assign reg_val    = bus_if.register_b;
`endif

    // Operand-B source multiplexer on the incoming bundle.
    always_comb begin
        operand = reg_val;
        unique case (bus_if.alu_src_b)
            2'd0: operand = reg_val;
            2'd1: operand = WIDTH'(CONST_B);
            2'd2: operand = extend_imm(bus_if.opcode, bus_if.immediate);
            2'd3: operand = extend_imm(bus_if.opcode, bus_if.immediate) << SHIFT;
            default: operand = reg_val;
        endcase
    end

    // Handshake: ready depends only on the skid being empty (and reset).
    assign bus_if.in_ready  = !reset && (state_q != FULL);
    assign bus_if.out_valid = (state_q != EMPTY);
    assign bus_if.alu_b     = out_data_q;
    assign accept           = bus_if.in_valid && bus_if.in_ready;
    assign drain            = bus_if.out_valid && bus_if.out_ready;

    // Occupancy FSM next state and data routing between output and skid.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    out_data_d = operand;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_data_d = operand;
                end else if (accept) begin
                    state_d     = FULL;
                    skid_data_d = operand;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d    = ONE;
                    out_data_d = skid_data_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control and visible output register; reset clears both.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end

    // Skid data holds no reset: it is only read while the FSM marks it full.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Testbench for alu_srcb_stage: directed scenarios plus randomized traffic,
// checked against a queue-based reference of the operand stream.
module tb_alu_srcb_stage;

    logic clk = 1'b0;
    logic rst_r;
    always #5 clk = ~clk;

    alu_srcb_stage_if #(.WIDTH(32), .IMM_WIDTH(16)) bus ();

    alu_srcb_stage #(
        .WIDTH(32), .IMM_WIDTH(16), .SHIFT(2), .CONST_B(4)
    ) dut (
        .clk    (clk),
        .reset  (rst_r),
        .bus_if (bus)
    );

`ifdef ALU_SRCB_FWD_EN
    localparam logic [31:0] FWD_HIT_EXP = 32'h22;
`else
    localparam logic [31:0] FWD_HIT_EXP = 32'h11;
`endif

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference operand value from the extension/selection rules (WIDTH=32).
    function automatic logic [31:0] ref_b(
        input logic [5:0] op, input logic [15:0] imm, input logic [1:0] src,
        input logic [31:0] rb, input logic [4:0] rt, input logic wv,
        input logic [4:0] wi, input logic [31:0] wd);
        logic [31:0] ext;
        logic [31:0] r;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) ext = {16'h0000, imm};
        else if (op == 6'h0F)                          ext = {imm, 16'h0000};
        else                                           ext = {{16{imm[15]}}, imm};
        r = rb;
`ifdef ALU_SRCB_FWD_EN
        if (wv && wi == rt && rt != 5'd0) r = wd;
`else
        if (wv && wi == rt && rt != 5'd0) r = rb;
`endif
        case (src)
            2'd0:    return r;
            2'd1:    return 32'd4;
            2'd2:    return ext;
            default: return ext * 32'd4;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [15:0] imm,
                         input logic [1:0] src, input logic [31:0] rb, input logic [4:0] rt,
                         input logic wv, input logic [4:0] wi, input logic [31:0] wd,
                         input logic ordy);
        bus.in_valid   = v;
        bus.opcode     = op;
        bus.immediate  = imm;
        bus.alu_src_b  = src;
        bus.register_b = rb;
        bus.rt_index   = rt;
        bus.wb_valid   = wv;
        bus.wb_index   = wi;
        bus.wb_data    = wd;
        bus.out_ready  = ordy;
    endtask

    // Advance one clock: update the FIFO model from the pre-edge inputs,
    // then compare the DUT's registered view after the edge.
    task automatic tick();
        bit acc, drn;
        logic [31:0] v;
        acc = bus.in_valid && !rst_r && (exp_q.size() < 2);
        drn = (exp_q.size() != 0) && bus.out_ready;
        v   = ref_b(bus.opcode, bus.immediate, bus.alu_src_b, bus.register_b,
                    bus.rt_index, bus.wb_valid, bus.wb_index, bus.wb_data);
        if (rst_r) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(v);
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("alu_b", 64'(bus.alu_b), 64'(exp_q[0]));
        check("in_ready", 64'(bus.in_ready), 64'(!rst_r && exp_q.size() < 2));
    endtask

    initial begin
        logic [5:0] op;
        // Reset state
        rst_r = 1'b1;
        drive(1, 6'h00, 16'h1234, 2'd0, 32'hDEAD, 5'd0, 0, 5'd0, 32'h0, 1'b0);
        tick();
        check("rst_alu_b", 64'(bus.alu_b), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h0);
        rst_r = 1'b0;
        drive(0, 6'h00, 16'h0, 2'd0, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);

        // Extension, shift and constant
        drive(1, 6'h23, 16'h8000, 2'd2, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        tick(); check("ext_sign", 64'(bus.alu_b), 64'hFFFF8000);
        drive(1, 6'h0D, 16'h8000, 2'd2, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        tick(); check("ext_zero", 64'(bus.alu_b), 64'h00008000);
        drive(1, 6'h0F, 16'h8000, 2'd2, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        tick(); check("ext_lui", 64'(bus.alu_b), 64'h80000000);
        drive(1, 6'h04, 16'hFFFF, 2'd3, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        tick(); check("ext_shift", 64'(bus.alu_b), 64'hFFFFFFFC);
        drive(1, 6'h04, 16'hFFFF, 2'd1, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        tick(); check("const_b", 64'(bus.alu_b), 64'h00000004);
        drive(0, 6'h00, 16'h0, 2'd0, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1);
        tick(); check("drain_empty", 64'(bus.out_valid), 64'h0);

        // Backpressure: A in output, B in skid, C stalls, then in-order drain
        drive(1, 6'h00, 16'h0, 2'd0, 32'hA, 5'd0, 0, 5'd0, 32'h0, 1'b0); tick();
        drive(1, 6'h00, 16'h0, 2'd0, 32'hB, 5'd0, 0, 5'd0, 32'h0, 1'b0); tick();
        check("bp_full_ready", 64'(bus.in_ready), 64'h0);
        drive(1, 6'h00, 16'h0, 2'd0, 32'hC, 5'd0, 0, 5'd0, 32'h0, 1'b0); tick();
        check("bp_hold_a", 64'(bus.alu_b), 64'hA);
        drive(1, 6'h00, 16'h0, 2'd0, 32'hC, 5'd0, 0, 5'd0, 32'h0, 1'b1); tick();
        check("bp_b", 64'(bus.alu_b), 64'hB);
        tick();
        check("bp_c", 64'(bus.alu_b), 64'hC);
        drive(0, 6'h00, 16'h0, 2'd0, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1); tick();
        check("bp_done", 64'(bus.out_valid), 64'h0);

        // Reset while FULL
        drive(1, 6'h00, 16'h0, 2'd0, 32'h5A, 5'd0, 0, 5'd0, 32'h0, 1'b0); tick();
        drive(1, 6'h00, 16'h0, 2'd0, 32'h5B, 5'd0, 0, 5'd0, 32'h0, 1'b0); tick();
        rst_r = 1'b1;
        drive(1, 6'h00, 16'h0, 2'd0, 32'h5C, 5'd0, 0, 5'd0, 32'h0, 1'b1); tick();
        check("rstfull_valid", 64'(bus.out_valid), 64'h0);
        check("rstfull_alu_b", 64'(bus.alu_b), 64'h0);
        rst_r = 1'b0;
        drive(0, 6'h00, 16'h0, 2'd0, 32'h0, 5'd0, 0, 5'd0, 32'h0, 1'b1); tick();
        check("rstfull_ready", 64'(bus.in_ready), 64'h1);

        // Forwarding
        drive(1, 6'h00, 16'h0, 2'd0, 32'h11, 5'd5, 1, 5'd5, 32'h22, 1'b1); tick();
        check("fwd_hit", 64'(bus.alu_b), 64'(FWD_HIT_EXP));
        drive(1, 6'h00, 16'h0, 2'd0, 32'h11, 5'd0, 1, 5'd0, 32'h22, 1'b1); tick();
        check("fwd_r0", 64'(bus.alu_b), 64'h11);

        // Randomized traffic with sporadic reset and back-pressure
        for (int i = 0; i < 500; i++) begin
            rst_r = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 5))
                0: op = 6'h0C; 1: op = 6'h0D; 2: op = 6'h0E; 3: op = 6'h0F;
                default: op = 6'($urandom);
            endcase
            drive(1'($urandom), op, 16'($urandom), 2'($urandom), $urandom,
                  5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                  $urandom, ($urandom_range(0, 3) != 0));
            tick();
        end

        rst_r = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
